// File: rtl/aes_pkg.sv
// Shared AES datapath helpers: byte type and ShiftRows geometry (row offsets, byte slicing, legal NB).
package aes_pkg;

   typedef logic [7:0] aes_byte_t;

   localparam int unsigned ROWS = 4;

   // Rijndael row rotation; the 256-bit block uses 0,1,3,4 instead of 0,1,2,3
   function automatic int unsigned shift_off(input int unsigned nb, input int unsigned r);
      if (nb == 8 && r >= 2) return r + 1;
      return r;
   endfunction

   // Column-major byte number of state[r][c]; byte 0 sits at the MSB of the word
   function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
      return ROWS * c + r;
   endfunction

   function automatic bit nb_legal(input int unsigned nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Pure-wiring ShiftRows (INV=0) or InvShiftRows (INV=1) permutation over 4*NB elements of EW bits.
// MSB0 selects whether element 0 sits at the MSB (data bytes) or at bit 0 (parity bits).
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter int unsigned  NB   = 4,
   parameter bit           INV  = 1'b0,
   parameter int unsigned  EW   = 8,
   parameter bit           MSB0 = 1'b1,
   localparam int unsigned T    = ROWS * NB * EW
) (
   input  logic [T-1:0] i_data,
   output logic [T-1:0] o_data
);

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int unsigned S   = shift_off(NB, r);
         localparam int unsigned SRC = INV ? (c + NB - S) % NB : (c + S) % NB;
         localparam int unsigned KO  = byte_idx(r, c);
         localparam int unsigned KI  = byte_idx(r, SRC);
         localparam int unsigned PO  = MSB0 ? (T - 1 - EW * KO) : (EW * KO + EW - 1);
         localparam int unsigned PI  = MSB0 ? (T - 1 - EW * KI) : (EW * KI + EW - 1);
         assign o_data[PO -: EW] = i_data[PI -: EW];
      end
   end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows stage with valid/ready and a 2-entry skid (M + S).
// Optional parity passthrough and sticky error flag under `define SHIFT_ROWS_PARITY_EN.
module shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int unsigned  NB     = 4,
   localparam int unsigned W      = 32 * NB,
   localparam int unsigned NBYTES = ROWS * NB
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_inv,
   input  logic [W-1:0]      dataIn,
`ifdef SHIFT_ROWS_PARITY_EN
   input  logic [NBYTES-1:0] in_par,
   output logic [NBYTES-1:0] out_par,
   output logic              par_err,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      dataOut,
   output logic              out_inv
);

   if (!nb_legal(NB)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end

   // Payload held in M/S: {parity (optional), inv, permuted data}
`ifdef SHIFT_ROWS_PARITY_EN
   localparam int unsigned PW = W + 1 + NBYTES;
`else
   localparam int unsigned PW = W + 1;
`endif

   logic [W-1:0]  w_fwd;
   logic [W-1:0]  w_inv;
   logic [PW-1:0] w_pay_in;

   logic          r_m_valid;
   logic          r_s_valid;
   logic          r_in_ready;
   logic [PW-1:0] r_m_pay;
   logic [PW-1:0] r_s_pay;

   logic          w_m_valid_nx;
   logic          w_s_valid_nx;
   logic [PW-1:0] w_m_pay_nx;
   logic [PW-1:0] w_s_pay_nx;
   logic          w_in_fire;
   logic          w_out_fire;

   shift_rows_perm #(.NB(NB), .INV(1'b0)) u_perm_fwd (.i_data(dataIn), .o_data(w_fwd));
   shift_rows_perm #(.NB(NB), .INV(1'b1)) u_perm_inv (.i_data(dataIn), .o_data(w_inv));

`ifdef SHIFT_ROWS_PARITY_EN
   logic [NBYTES-1:0] w_par_fwd;
   logic [NBYTES-1:0] w_par_inv;
   logic [NBYTES-1:0] w_par_bad;
   logic              r_par_err;

   shift_rows_perm #(.NB(NB), .INV(1'b0), .EW(1), .MSB0(1'b0)) u_par_fwd (.i_data(in_par), .o_data(w_par_fwd));
   shift_rows_perm #(.NB(NB), .INV(1'b1), .EW(1), .MSB0(1'b0)) u_par_inv (.i_data(in_par), .o_data(w_par_inv));

   // Odd parity: a byte is bad when its parity bit equals the XOR of its data bits
   for (genvar k = 0; k < NBYTES; k++) begin : g_par
      aes_byte_t w_b;
      assign w_b          = dataIn[W-1-8*k -: 8];
      assign w_par_bad[k] = in_par[k] ~^ (^w_b);
   end

   assign w_pay_in = {(in_inv ? w_par_inv : w_par_fwd), in_inv, (in_inv ? w_inv : w_fwd)};
   assign out_par  = r_m_pay[PW-1 -: NBYTES];
   assign par_err  = r_par_err;

   always_ff @(posedge clk) begin
      if (reset) r_par_err <= 1'b0;
      else if (w_in_fire && (|w_par_bad)) r_par_err <= 1'b1;
   end
`else
   assign w_pay_in = {in_inv, (in_inv ? w_inv : w_fwd)};
`endif

   assign w_in_fire  = in_valid && r_in_ready;
   assign w_out_fire = r_m_valid && out_ready;

   // Next-state for the M/S skid pair
   always_comb begin
      w_m_valid_nx = r_m_valid;
      w_s_valid_nx = r_s_valid;
      w_m_pay_nx   = r_m_pay;
      w_s_pay_nx   = r_s_pay;
      if (r_s_valid) begin
         if (w_out_fire) begin
            w_m_pay_nx   = r_s_pay;
            w_s_valid_nx = 1'b0;
         end
      end else if (!r_m_valid || w_out_fire) begin
         w_m_valid_nx = w_in_fire;
         if (w_in_fire) w_m_pay_nx = w_pay_in;
      end else if (w_in_fire) begin
         w_s_valid_nx = 1'b1;
         w_s_pay_nx   = w_pay_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_m_valid  <= 1'b0;
         r_s_valid  <= 1'b0;
         r_in_ready <= 1'b1;
         r_m_pay    <= '0;
         r_s_pay    <= '0;
      end else begin
         r_m_valid  <= w_m_valid_nx;
         r_s_valid  <= w_s_valid_nx;
         r_in_ready <= !w_s_valid_nx;
         r_m_pay    <= w_m_pay_nx;
         r_s_pay    <= w_s_pay_nx;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_m_valid;
   assign dataOut   = r_m_pay[W-1:0];
   assign out_inv   = r_m_pay[W];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4 and NB=8 instances, backpressure, reset, optional parity.
module tb_shift_rows_pipe;

   logic         clk = 1'b0;
   logic         reset;
   logic         v4, rdy4, inv4, ov4, or4, oinv4;
   logic [127:0] d4, q4;
   logic         v8, rdy8, inv8, ov8, or8, oinv8;
   logic [255:0] d8, q8;

   int n_chk  = 0;
   int n_pass = 0;
   int last_lat;

   always #5 clk = ~clk;

   function automatic logic [31:0] par_fn(input logic [255:0] d, input int nbytes);
      logic [31:0] p;
      p = '0;
      for (int k = 0; k < nbytes; k++) p[k] = ~^d[8*nbytes-1-8*k -: 8];
      return p;
   endfunction

`ifdef SHIFT_ROWS_PARITY_EN
   logic [15:0] par4, opar4, par_flip4;
   logic [31:0] par8, opar8;
   logic        perr4, perr8;
   assign par4 = par_fn({128'b0, d4}, 16) ^ {16'b0, par_flip4};
   assign par8 = par_fn(d8, 32);
`endif

   shift_rows_pipe #(.NB(4)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4), .in_inv(inv4), .dataIn(d4),
`ifdef SHIFT_ROWS_PARITY_EN
      .in_par(par4), .out_par(opar4), .par_err(perr4),
`endif
      .out_valid(ov4), .out_ready(or4), .dataOut(q4), .out_inv(oinv4));

   shift_rows_pipe #(.NB(8)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .in_inv(inv8), .dataIn(d8),
`ifdef SHIFT_ROWS_PARITY_EN
      .in_par(par8), .out_par(opar8), .par_err(perr8),
`endif
      .out_valid(ov8), .out_ready(or8), .dataOut(q8), .out_inv(oinv8));

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Reference ShiftRows straight from the row/column definition
   function automatic logic [255:0] perm_m(input int nb, input logic inv, input logic [255:0] d);
      logic [255:0] q;
      int w, s, src;
      q = '0;
      w = 32 * nb;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < nb; c++) begin
            s   = (nb == 8 && r >= 2) ? r + 1 : r;
            src = inv ? (c + nb - s) % nb : (c + s) % nb;
            q[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
         end
      return q;
   endfunction

   // One word through the selected instance with out_ready held high
   task automatic xfer(input bit b8, input logic inv, input logic [255:0] d,
                       output logic [255:0] q, output logic qinv);
      int n;
      @(negedge clk);
      if (b8) begin v8 = 1'b1; inv8 = inv; d8 = d; end
      else begin v4 = 1'b1; inv4 = inv; d4 = d[127:0]; end
      n = 0;
      while (!(b8 ? rdy8 : rdy4) && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("in_ready_timeout", 0, 1);
      @(negedge clk);
      v4 = 1'b0;
      v8 = 1'b0;
      n = 0;
      while (!(b8 ? ov8 : ov4) && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("out_valid_timeout", 0, 1);
      last_lat = n;
      q    = b8 ? q8 : {128'b0, q4};
      qinv = b8 ? oinv8 : oinv4;
   endtask

   logic [255:0] q, f, g, d;
   logic         qi;
   logic [127:0] w [4];
   int           nacc, nout, stale;

   initial begin
      reset = 1'b1;
      v4 = 1'b0; inv4 = 1'b0; d4 = '0; or4 = 1'b1;
      v8 = 1'b0; inv8 = 1'b0; d8 = '0; or8 = 1'b1;
`ifdef SHIFT_ROWS_PARITY_EN
      par_flip4 = '0;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", ov4, 0);
      chk("rst_in_ready", rdy4, 1);
      chk("rst_dataout", q4, 0);
      chk("rst_out_inv", oinv4, 0);
      chk("rst_in_ready8", rdy8, 1);

      // NB=4 forward / inverse known vectors
      xfer(1'b0, 1'b0, {128'b0, 128'h000102030405060708090a0b0c0d0e0f}, q, qi);
      chk("fwd4", q, {128'b0, 128'h00050a0f04090e03080d02070c01060b});
      chk("fwd4_latency", last_lat, 0);
      chk("fwd4_inv", qi, 0);
      xfer(1'b0, 1'b1, {128'b0, 128'h00050a0f04090e03080d02070c01060b}, q, qi);
      chk("inv4", q, {128'b0, 128'h000102030405060708090a0b0c0d0e0f});
      chk("inv4_inv", qi, 1);

      // NB=8 forward on bytes 00..1f
      d = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      xfer(1'b1, 1'b0, d, q, qi);
      chk("fwd8_col0", q[255:224], 32'h00050e13);
      chk("fwd8_col7", q[31:0], 32'h1c010a0f);
      chk("fwd8_full", q, perm_m(8, 1'b0, d));

      // Random forward/inverse round trips on NB=8
      for (int i = 0; i < 1000; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         xfer(1'b1, 1'b0, d, f, qi);
         chk("rand_fwd8", f, perm_m(8, 1'b0, d));
         xfer(1'b1, 1'b1, f, g, qi);
         chk("rand_roundtrip8", g, d);
      end

      // Backpressure: 5 stalled cycles, 4-word stream
      for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom, $urandom, $urandom};
      nacc = 0;
      nout = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(negedge clk);
         or4 = (cyc >= 5);
         inv4 = 1'b0;
         if (nacc < 4) begin v4 = 1'b1; d4 = w[nacc]; end
         else v4 = 1'b0;
         if (cyc == 5) begin
            chk("bp_accepts", nacc, 2);
            chk("bp_in_ready", rdy4, 0);
         end
         if (ov4 && or4) begin
            if (nout < 4) begin
               chk("bp_order", q4, perm_m(4, 1'b0, {128'b0, w[nout]}));
               chk("bp_rate", cyc, 5 + nout);
            end
            nout++;
         end
         if (v4 && rdy4) nacc++;
      end
      v4 = 1'b0;
      chk("bp_out_count", nout, 4);

      // Reset with M and S both full
      @(negedge clk);
      or4 = 1'b0;
      nacc = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (nacc < 2) begin v4 = 1'b1; d4 = w[nacc]; end
         else v4 = 1'b0;
         if (v4 && rdy4) nacc++;
         @(negedge clk);
      end
      v4 = 1'b0;
      chk("pre_rst_full", {ov4, rdy4}, 2'b10);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", ov4, 0);
      chk("mid_rst_in_ready", rdy4, 1);
      chk("mid_rst_dataout", q4, 0);
      reset = 1'b0;
      or4 = 1'b1;
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (ov4) stale++;
      end
      chk("rst_no_stale", stale, 0);

`ifdef SHIFT_ROWS_PARITY_EN
      chk("par_err_clear", perr4, 0);
      par_flip4 = 16'h0020;
      xfer(1'b0, 1'b0, {128'b0, 128'h000102030405060708090a0b0c0d0e0f}, q, qi);
      par_flip4 = 16'h0000;
      chk("par_bad_data", q, {128'b0, 128'h00050a0f04090e03080d02070c01060b});
      chk("par_bad_outpar", opar4,
          par_fn({128'b0, 128'h00050a0f04090e03080d02070c01060b}, 16) ^ 32'h0002);
      @(negedge clk);
      chk("par_err_set", perr4, 1);
      xfer(1'b0, 1'b1, {128'b0, 128'h00050a0f04090e03080d02070c01060b}, q, qi);
      chk("par_good_outpar", opar4, par_fn({128'b0, 128'h000102030405060708090a0b0c0d0e0f}, 16));
      chk("par_err_sticky", perr4, 1);
      chk("par_err8_clear", perr8, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
